// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential 16/8 restoring divider, one quotient bit per clock
//
// Purpose: divides a 16-bit dividend by an 8-bit divisor, producing an 8-bit
// quotient and 8-bit remainder, with divide-by-zero and quotient-overflow flags.
// Optional feature macro: DIV_SIGNED_EN (two's-complement operands and signed
// fix-up; when undefined the operands are unsigned).
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous active-high reset
//   start  in   1   request, sampled only in IDLE
//   N      in  16   dividend
//   M      in   8   divisor
//   Q      out  8   quotient (held until next accepted start)
//   R      out  8   remainder (held until next accepted start)
//   busy   out  1   high in CHK, DIV, FIX
//   done   out  1   one-cycle pulse in DONE
//   dz     out  1   divide-by-zero flag
//   ovf    out  1   quotient-overflow flag
//   u      out  4   iteration counter, 0..8
module restoring_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] N,
  input  logic [7:0]  M,
  output logic [7:0]  Q,
  output logic [7:0]  R,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic        ovf,
  output logic [3:0]  u
);

  typedef enum logic [2:0] {IDLE, CHK, DIV, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [16:0] n_mag;
  logic [8:0]  m_mag;
  logic [8:0]  a;
  logic [7:0]  qr;

  logic [16:0] n_abs;
  logic [8:0]  m_abs;

  // Operand magnitudes and FIX-stage results depend on the signedness build.
  logic        fix_ovf;
  logic [7:0]  q_fix;
  logic [7:0]  r_fix;

`ifdef DIV_SIGNED_EN
  logic sn, sm;
  logic neg_q;

  // Negating the sign-extended operand gives the magnitude; 17 bits keeps
  // |-32768| representable, 9 bits keeps |-128| representable.
  assign n_abs = N[15] ? (17'd0 - {1'b1, N}) : {1'b0, N};
  assign m_abs = M[7]  ? (9'd0  - {1'b1, M}) : {1'b0, M};

  assign neg_q = sn ^ sm;
  // A magnitude of 128 only fits as a negative quotient (-128).
  assign fix_ovf = qr[7] && !((qr == 8'h80) && neg_q);
  assign q_fix   = neg_q ? (8'd0 - qr) : qr;
  assign r_fix   = sn ? (8'd0 - a[7:0]) : a[7:0];
`else
  assign n_abs   = {1'b0, N};
  assign m_abs   = {1'b0, M};
  assign fix_ovf = 1'b0;
  assign q_fix   = qr;
  assign r_fix   = a[7:0];
`endif

  // CHK decisions. Bit 16 of the magnitude can only be set alongside an
  // overflowing upper byte, so comparing [16:8] is equivalent to [15:8].
  logic chk_dz, chk_ovf;
  assign chk_dz  = (m_mag == 9'd0);
  assign chk_ovf = (n_mag[16:8] >= m_mag);

  // One restoring step: shift {A,Qr} left, trial-subtract |M|.
  logic [9:0] sh;
  logic [8:0] diff;
  logic       ge;
  assign sh   = {a, qr[7]};
  assign ge   = (sh >= {1'b0, m_mag});
  assign diff = sh[8:0] - m_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CHK;
      end
      CHK: begin
        busy = 1'b1;
        if (chk_dz || chk_ovf) state_nxt = DONE;
        else                   state_nxt = DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (u == 4'd7) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_mag <= '0;
      m_mag <= '0;
      a     <= '0;
      qr    <= '0;
      u     <= '0;
      Q     <= '0;
      R     <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
`ifdef DIV_SIGNED_EN
      sn    <= 1'b0;
      sm    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_mag <= n_abs;
            m_mag <= m_abs;
`ifdef DIV_SIGNED_EN
            sn    <= N[15];
            sm    <= M[7];
`endif
            dz    <= 1'b0;
            ovf   <= 1'b0;
            u     <= 4'd0;
          end
        end
        CHK: begin
          if (chk_dz) begin
            dz <= 1'b1;
            Q  <= '0;
            R  <= '0;
          end else if (chk_ovf) begin
            ovf <= 1'b1;
            Q   <= '0;
            R   <= '0;
          end else begin
            a  <= {1'b0, n_mag[15:8]};
            qr <= n_mag[7:0];
          end
        end
        DIV: begin
          a  <= ge ? diff : sh[8:0];
          qr <= {qr[6:0], ge};
          u  <= u + 4'd1;
        end
        FIX: begin
          if (fix_ovf) begin
            ovf <= 1'b1;
            Q   <= '0;
            R   <= '0;
          end else begin
            Q <= q_fix;
            R <= r_fix;
          end
        end
        DONE: begin
          u <= 4'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - self-checking bench for restoring_divider
module tb_restoring_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] n;
  logic [7:0]  m;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        busy;
  logic        done;
  logic        dz;
  logic        ovf;
  logic [3:0]  u;

  always #5 clk = ~clk;

  restoring_divider dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .N     (n),
    .M     (m),
    .Q     (q),
    .R     (r),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .ovf   (ovf),
    .u     (u)
  );

  typedef struct {
    logic [15:0] n;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [15:0] nn, input logic [7:0] mm,
                              input logic [7:0] qq, input logic [7:0] rr,
                              input logic d, input logic o, input int l);
    vec_t v;
    v.n = nn; v.m = mm; v.q = qq; v.r = rr; v.dz = d; v.ovf = o; v.lat = l;
    return v;
  endfunction

  // Arithmetic reference: integer division truncating toward zero.
  function automatic vec_t model(input logic [15:0] nn, input logic [7:0] mm);
    vec_t v;
    int nv, mv, an, am, qm, rm;
    logic neg_n, neg_q;
`ifdef DIV_SIGNED_EN
    nv = $signed(nn);
    mv = $signed(mm);
`else
    nv = int'(nn);
    mv = int'(mm);
`endif
    an = (nv < 0) ? -nv : nv;
    am = (mv < 0) ? -mv : mv;
    neg_n = (nv < 0);
    neg_q = (nv < 0) != (mv < 0);
    v = mk(nn, mm, 8'd0, 8'd0, 1'b0, 1'b0, 11);
    if (am == 0) begin
      v.dz = 1'b1; v.lat = 2;
    end else if ((an / 256) >= am) begin
      v.ovf = 1'b1; v.lat = 2;
    end else begin
      qm = an / am;
      rm = an % am;
      if (qm > 127 && !(qm == 128 && neg_q)) begin
`ifdef DIV_SIGNED_EN
        v.ovf = 1'b1;
`else
        v.q = 8'(qm);
        v.r = 8'(rm);
`endif
      end else begin
        v.q = 8'(neg_q ? -qm : qm);
        v.r = 8'(neg_n ? -rm : rm);
      end
    end
    return v;
  endfunction

  // Caller is at a negedge; start is driven immediately so back-to-back
  // operations start in the IDLE cycle right after done.
  task automatic run_vec(input vec_t e);
    vec_t exp_v;
    int   cyc, bc;
    n = e.n; m = e.m; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    bc  = 0;
    while (!done && cyc < 40) begin
      if (busy) bc++;
      @(negedge clk);
      cyc++;
    end
    exp_v = sb.pop_front();
    if (!done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("latency", cyc, exp_v.lat);
      chk("Q", int'(q), int'(exp_v.q));
      chk("R", int'(r), int'(exp_v.r));
      chk("dz", int'(dz), int'(exp_v.dz));
      chk("ovf", int'(ovf), int'(exp_v.ovf));
      chk("busy_cycles", bc, exp_v.lat - 1);
      chk("busy_with_done", int'(busy), 0);
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_Q"}, int'(q), 0);
    chk({tag, "_R"}, int'(r), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_dz"}, int'(dz), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_u"}, int'(u), 0);
  endtask

  initial begin
    vec_t e;
    int   cyc, dcnt, dcyc;
    logic [15:0] nn;
    logic [7:0]  mm;

    rst = 1'b1; start = 1'b0; n = '0; m = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

`ifdef DIV_SIGNED_EN
    tbl.push_back(mk(16'd100,  8'd7,    8'd14,  8'd2,   1'b0, 1'b0, 11));
    tbl.push_back(mk(16'hFF9C, 8'd7,    8'hF2,  8'hFE,  1'b0, 1'b0, 11));
    tbl.push_back(mk(16'd100,  8'hF9,   8'hF2,  8'd2,   1'b0, 1'b0, 11));
    tbl.push_back(mk(16'hFF9C, 8'hF9,   8'd14,  8'hFE,  1'b0, 1'b0, 11));
    tbl.push_back(mk(16'hFF00, 8'd2,    8'h80,  8'd0,   1'b0, 1'b0, 11));
    tbl.push_back(mk(16'd256,  8'd2,    8'd0,   8'd0,   1'b0, 1'b1, 11));
    tbl.push_back(mk(16'd1234, 8'd0,    8'd0,   8'd0,   1'b1, 1'b0, 2));
    tbl.push_back(mk(16'd1000, 8'd3,    8'd0,   8'd0,   1'b0, 1'b1, 2));
    tbl.push_back(mk(16'h8000, 8'h80,   8'd0,   8'd0,   1'b0, 1'b1, 2));
    tbl.push_back(mk(16'hFFFF, 8'd1,    8'hFF,  8'd0,   1'b0, 1'b0, 11));
    tbl.push_back(mk(16'hFFF9, 8'd2,    8'hFD,  8'hFF,  1'b0, 1'b0, 11));
`else
    tbl.push_back(mk(16'd100,  8'd7,    8'd14,  8'd2,   1'b0, 1'b0, 11));
    tbl.push_back(mk(16'hFE01, 8'hFF,   8'hFF,  8'd0,   1'b0, 1'b0, 11));
    tbl.push_back(mk(16'hFF00, 8'hFF,   8'd0,   8'd0,   1'b0, 1'b1, 2));
    tbl.push_back(mk(16'd1000, 8'd0,    8'd0,   8'd0,   1'b1, 1'b0, 2));
    tbl.push_back(mk(16'd1000, 8'd3,    8'd0,   8'd0,   1'b0, 1'b1, 2));
    tbl.push_back(mk(16'h00FF, 8'd1,    8'hFF,  8'd0,   1'b0, 1'b0, 11));
    tbl.push_back(mk(16'h1234, 8'h56,   8'h36,  8'h10,  1'b0, 1'b0, 11));
    tbl.push_back(mk(16'd0,    8'd5,    8'd0,   8'd0,   1'b0, 1'b0, 11));
`endif

    foreach (tbl[i]) run_vec(tbl[i]);

    for (int i = 0; i < 16; i++) begin
      nn = 16'($urandom_range(0, 65535) >> $urandom_range(0, 8));
      mm = 8'($urandom_range(1, 255));
      run_vec(model(nn, mm));
    end

    // Reset in the middle of DIV aborts without done.
    n = 16'd100; m = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (u != 4'd4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_u4", int'(u), 4);
    rst = 1'b1;
    @(negedge clk);
    chk_zero_outputs("midrst");
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("no_done_after_reset", dcnt, 0);

    // start held high through the whole operation: exactly one done.
    e = model(16'd100, 8'd7);
    n = e.n; m = e.m; start = 1'b1;
    sb.push_back(e);
    dcnt = 0;
    dcyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        start = 1'b0;
        if (dcnt == 1) begin
          dcyc = i;
          e = sb.pop_front();
          chk("held_Q", int'(q), int'(e.q));
          chk("held_R", int'(r), int'(e.r));
        end
      end
    end
    chk("held_done_count", dcnt, 1);
    chk("held_latency", dcyc, 11);
    start = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
